// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared defines for the pipeline controller: stall vector bit
//               indices, Stop/NoStop levels, exception type codes, FSM states
//               and the prefix-form stall vector builder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  // Stall vector bit positions (1 = Stop)
  localparam int unsigned c_stall_pc   = 0;
  localparam int unsigned c_stall_ifid = 1;
  localparam int unsigned c_stall_idex = 2;
  localparam int unsigned c_stall_exmm = 3;
  localparam int unsigned c_stall_mmwb = 4;
  localparam int unsigned c_stall_rsvd = 5;
  localparam int unsigned c_stall_w    = 6;

  localparam logic c_stop   = 1'b1;
  localparam logic c_nostop = 1'b0;

  // Exception type codes delivered by the MEM stage
  localparam logic [31:0] c_exc_none     = 32'h0000_0000;
  localparam logic [31:0] c_exc_int      = 32'h0000_0001;
  localparam logic [31:0] c_exc_syscall  = 32'h0000_0008;
  localparam logic [31:0] c_exc_inst_inv = 32'h0000_000a;
  localparam logic [31:0] c_exc_ov       = 32'h0000_000c;
  localparam logic [31:0] c_exc_trap     = 32'h0000_000d;
  localparam logic [31:0] c_exc_eret     = 32'h0000_000e;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_GUARD = 1'b1
  } state_t;

  // A request from stage k stops stage k and everything upstream of it, so the
  // deepest requester decides how many low-order bits are set. The reserved
  // bit is never driven to Stop.
  function automatic logic [c_stall_w-1:0] prefix_stall(
    input logic req_mem,
    input logic req_ex,
    input logic req_id,
    input logic req_if
  );
    logic [c_stall_w-1:0] v;
    int unsigned          depth;
    if (req_mem)     depth = c_stall_mmwb + 1;
    else if (req_ex) depth = c_stall_exmm + 1;
    else if (req_id) depth = c_stall_idex + 1;
    else if (req_if) depth = c_stall_ifid + 1;
    else             depth = 0;
    for (int unsigned i = 0; i < c_stall_w; i++) begin
      v[i] = ((i < depth) && (i != c_stall_rsvd)) ? c_stop : c_nostop;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_watchdog.sv
// ============================================================================
// Module      : stall_watchdog
// Description : Counts consecutive cycles of a memory stall request and emits
//               a one-cycle timeout pulse every TIMEOUT cycles it persists.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stall_watchdog #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic clr,
  output logic timeout
);

  localparam int unsigned c_cnt_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               w_hit;

  assign w_hit   = req && !clr && (r_cnt == c_last);
  assign timeout = w_hit && !rst;

  // Run while the request persists; restart after each pulse or any break.
  always_ff @(posedge clk) begin
    if (rst || clr || !req || w_hit) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline controller: prefix-form stall vector, exception flush
//               with redirect target, one-cycle post-flush guard, memory bus
//               watchdog and saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter int unsigned TIMEOUT    = 256,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_timeout,
  output logic [31:0] stall_cycles
);

  import pipe_ctrl_pkg::*;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_stall_cycles;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  // Next state and zero-latency control outputs; flush outranks every stall
  // request, and the GUARD cycle ignores the exception still held in MEM.
  always_comb begin
    w_state_next = ST_RUN;
    stall        = '0;
    flush        = 1'b0;
    new_pc       = 32'h0;
    if (!rst) begin
      if ((r_state == ST_RUN) && (excepttype != c_exc_none)) begin
        flush        = 1'b1;
        new_pc       = (excepttype == c_exc_eret) ? cp0_epc : EXC_VECTOR;
        w_state_next = ST_GUARD;
      end else begin
        stall = prefix_stall(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);
      end
    end
  end

  // Saturating count of cycles in which the pc is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 32'h0;
    end else if ((stall[c_stall_pc] == c_stop) && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;

  stall_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .req     (stallreq_mem),
    .clr     (flush),
    .timeout (bus_timeout)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Directed self-checking bench for pipe_ctrl (TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic [31:0] excepttype;
  logic [31:0] cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        bus_timeout;
  logic [31:0] stall_cycles;

  int          n_checks;
  int          n_errors;
  logic [31:0] exp_sc;

  pipe_ctrl #(
    .TIMEOUT    (4),
    .EXC_VECTOR (32'h0000_0020)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_if  (stallreq_if),
    .stallreq_id  (stallreq_id),
    .stallreq_ex  (stallreq_ex),
    .stallreq_mem (stallreq_mem),
    .excepttype   (excepttype),
    .cp0_epc      (cp0_epc),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .bus_timeout  (bus_timeout),
    .stall_cycles (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; st0 says whether the pc was held in the cycle just ended.
  task automatic step(input bit st0);
    @(posedge clk);
    if (st0 && exp_sc != 32'hFFFF_FFFF) exp_sc = exp_sc + 32'd1;
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input bit m, input bit e, input bit d, input bit f);
    stallreq_mem = m;
    stallreq_ex  = e;
    stallreq_id  = d;
    stallreq_if  = f;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    exp_sc     = 32'h0;
    cp0_epc    = 32'h0;
    excepttype = 32'h0000_0008;
    rst        = 1'b1;
    set_req(1, 1, 0, 0);

    // Reset overrides active inputs
    @(negedge clk); #1;
    check("rst_stall",   {26'h0, stall}, 32'h0);
    check("rst_flush",   {31'h0, flush}, 32'h0);
    check("rst_new_pc",  new_pc,         32'h0);
    check("rst_timeout", {31'h0, bus_timeout}, 32'h0);
    step(0);
    check("rst_sc", stall_cycles, 32'h0);

    rst        = 1'b0;
    excepttype = 32'h0;
    set_req(0, 0, 0, 0);
    check("idle_stall", {26'h0, stall}, 32'h0);
    step(0);

    // Prefix encoding, deepest requester wins
    set_req(0, 1, 0, 1);
    check("ex_if_stall", {26'h0, stall}, 32'h0000_000F);
    check("ex_if_flush", {31'h0, flush}, 32'h0);
    step(1);
    check("sc_1", stall_cycles, 32'd1);
    step(1);
    check("sc_2", stall_cycles, 32'd2);
    set_req(0, 0, 1, 0);
    check("id_stall", {26'h0, stall}, 32'h0000_0007);
    step(1);
    set_req(0, 0, 0, 1);
    check("if_stall", {26'h0, stall}, 32'h0000_0003);
    step(1);
    set_req(1, 0, 1, 0);
    check("mem_id_stall", {26'h0, stall}, 32'h0000_001F);
    check("noflush_pc",   new_pc,         32'h0);
    step(1);
    check("sc_5", stall_cycles, exp_sc);

    // Syscall while mem stalls: flush wins, then GUARD ignores the code
    excepttype = 32'h0000_0008;
    set_req(1, 0, 0, 0);
    check("exc_flush",  {31'h0, flush}, 32'h1);
    check("exc_stall",  {26'h0, stall}, 32'h0);
    check("exc_new_pc", new_pc,         32'h0000_0020);
    step(0);
    check("guard_flush", {31'h0, flush}, 32'h0);
    check("guard_stall", {26'h0, stall}, 32'h0000_001F);
    step(1);
    excepttype = 32'h0;
    set_req(0, 0, 0, 0);
    check("run_idle_flush", {31'h0, flush}, 32'h0);
    step(0);

    // ERET redirects to EPC
    excepttype = 32'h0000_000e;
    cp0_epc    = 32'h8000_1234;
    #1;
    check("eret_flush",  {31'h0, flush}, 32'h1);
    check("eret_new_pc", new_pc,         32'h8000_1234);
    step(0);
    excepttype = 32'h0;
    step(0);
    // Unlisted nonzero code goes to the vector
    excepttype = 32'h0000_0055;
    #1;
    check("other_new_pc", new_pc, 32'h0000_0020);
    step(0);
    excepttype = 32'h0;
    step(0);
    check("sc_6", stall_cycles, exp_sc);

    // Bus watchdog with TIMEOUT=4: pulses on cycles 4 and 8 of 9
    set_req(1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      check($sformatf("wd_pulse_%0d", i), {31'h0, bus_timeout}, ((i == 4) || (i == 8)) ? 32'h1 : 32'h0);
      check($sformatf("wd_stall_%0d", i), {26'h0, stall}, 32'h0000_001F);
      step(1);
    end
    set_req(0, 0, 0, 0);
    check("wd_off", {31'h0, bus_timeout}, 32'h0);
    check("sc_15", stall_cycles, 32'd15);

    // Reset in the middle of a mem burst
    set_req(1, 0, 0, 0);
    step(1);
    rst = 1'b1;
    #1;
    check("mid_rst_stall",   {26'h0, stall}, 32'h0);
    check("mid_rst_timeout", {31'h0, bus_timeout}, 32'h0);
    step(0);
    excepttype = 32'h0000_0008;
    #1;
    check("mid_rst_flush",  {31'h0, flush}, 32'h0);
    check("mid_rst_new_pc", new_pc,         32'h0);
    step(0);
    exp_sc     = 32'h0;
    rst        = 1'b0;
    excepttype = 32'h0;
    set_req(0, 0, 0, 0);
    check("post_rst_sc", stall_cycles, 32'h0);
    set_req(1, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      check($sformatf("post_rst_wd_%0d", i), {31'h0, bus_timeout}, 32'h0);
      step(1);
    end
    set_req(0, 0, 0, 0);
    check("post_rst_sc3", stall_cycles, 32'd3);

    // Saturation of the stall counter
    force dut.r_stall_cycles = 32'hFFFF_FFFD;
    #1;
    release dut.r_stall_cycles;
    exp_sc = 32'hFFFF_FFFD;
    set_req(1, 0, 0, 0);
    step(1);
    check("sat_fe", stall_cycles, 32'hFFFF_FFFE);
    step(1);
    check("sat_ff", stall_cycles, 32'hFFFF_FFFF);
    step(1);
    check("sat_hold", stall_cycles, 32'hFFFF_FFFF);
    check("sat_model", stall_cycles, exp_sc);
    set_req(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
